// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ROM.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties, no last-grant state).
module rom_arbiter #(
  parameter  int unsigned W = 32,
  parameter  int unsigned L = 16,
  localparam int unsigned A = (L > 1) ? $clog2(L) : 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  output logic [A-1:0] rom_address,
  output logic         rom_oe,
  input  logic [W-1:0] rom_data,
  output logic [W-1:0] rdata,
  output logic         valid0,
  output logic         valid1,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic [A-1:0] r_addr_q;
  logic         r_gnt_q;
  logic [W-1:0] r_rdata;
  logic         r_valid0;
  logic         r_valid1;
  logic         r_busy;
  logic         r_rom_oe;

  state_t       w_state_nxt;
  logic [A-1:0] w_addr_nxt;
  logic         w_gnt_nxt;
  logic [W-1:0] w_rdata_nxt;
  logic         w_valid0_nxt;
  logic         w_valid1_nxt;
  logic         w_win;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Port 1 only wins when port 0 is not requesting.
  always_comb w_win = ~req0;
`else
  logic r_last_gnt;
  logic w_last_nxt;

  // On a tie the port not granted last wins; otherwise the lone requester wins.
  always_comb w_win = (req0 & req1) ? ~r_last_gnt : ~req0;
`endif

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr_q;
    w_gnt_nxt    = r_gnt_q;
    w_rdata_nxt  = r_rdata;
    w_valid0_nxt = 1'b0;
    w_valid1_nxt = 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
    w_last_nxt   = r_last_gnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (req0 | req1) begin
          w_state_nxt = ST_READ;
          w_addr_nxt  = w_win ? addr1 : addr0;
          w_gnt_nxt   = w_win;
`ifndef ROM_ARB_FIXED_PRIO_EN
          w_last_nxt  = w_win;
`endif
        end
      end
      ST_READ: begin
        w_state_nxt  = ST_RESP;
        w_rdata_nxt  = rom_data;
        w_valid0_nxt = ~r_gnt_q;
        w_valid1_nxt = r_gnt_q;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; busy/rom_oe are registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr_q   <= '0;
      r_gnt_q    <= 1'b0;
      r_rdata    <= '0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_busy     <= 1'b0;
      r_rom_oe   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      r_last_gnt <= 1'b1;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_addr_q   <= w_addr_nxt;
      r_gnt_q    <= w_gnt_nxt;
      r_rdata    <= w_rdata_nxt;
      r_valid0   <= w_valid0_nxt;
      r_valid1   <= w_valid1_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_rom_oe   <= (w_state_nxt == ST_READ);
`ifndef ROM_ARB_FIXED_PRIO_EN
      r_last_gnt <= w_last_nxt;
`endif
    end
  end

  assign rom_address = r_addr_q;
  assign rom_oe      = r_rom_oe;
  assign rdata       = r_rdata;
  assign valid0      = r_valid0;
  assign valid1      = r_valid1;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_rom_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned L = 16;
  localparam int unsigned A = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0, req1;
  logic [A-1:0] addr0, addr1;
  logic [A-1:0] rom_address;
  logic         rom_oe;
  logic [W-1:0] rom_data;
  logic [W-1:0] rdata;
  logic         valid0, valid1, busy;

  logic [W-1:0] rom [L];

  always #5 clock = ~clock;

  // Junk on the data bus whenever the ROM is not enabled.
  assign rom_data = rom_oe ? rom[rom_address] : 32'hDEAD_BEEF;

  rom_arbiter #(.W(W), .L(L)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .rom_address(rom_address), .rom_oe(rom_oe), .rom_data(rom_data),
    .rdata(rdata), .valid0(valid0), .valid1(valid1), .busy(busy)
  );

  typedef struct {
    logic         rst_before;
    logic         r0, r1;
    logic [A-1:0] a0, a1;
    logic         exp_v0, exp_v1;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: cycles left in the current transaction (0 = free).
  int           m_left;
  logic         m_gnt, m_last;
  logic [A-1:0] m_addr;
  logic [W-1:0] m_rdata;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_gnt = 1'b0; m_last = 1'b1; m_addr = '0; m_rdata = '0;
  endtask

  task automatic check_outputs();
    check("busy", 32'(busy), 32'(m_left != 0));
    check("rom_oe", 32'(rom_oe), 32'(m_left == 2));
    check("rom_address", 32'(rom_address), 32'(m_addr));
    check("valid0", 32'(valid0), 32'(m_left == 1 && !m_gnt));
    check("valid1", 32'(valid1), 32'(m_left == 1 && m_gnt));
    check("rdata", rdata, m_rdata);
    check("valid_excl", 32'(valid0 & valid1), 32'd0);
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared.
  task automatic tick();
    logic r0, r1, w;
    logic [A-1:0] a0, a1;
    r0 = req0; r1 = req1; a0 = addr0; a1 = addr1;
    @(posedge clock);
    if (m_left == 0) begin
      if (r0 | r1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        w = !r0;
`else
        w = (r0 && r1) ? !m_last : r1;
`endif
        m_gnt = w; m_last = w; m_addr = w ? a1 : a0; m_left = 2;
      end
    end else if (m_left == 2) begin
      m_rdata = rom[m_addr];
      m_left = 1;
    end else begin
      m_left = 0;
    end
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    int   sweep_start, busy_cnt, g;

    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    for (int i = 0; i < int'(L); i++) rom[i] = $urandom;
    rom[3] = 32'h0000_0003;
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Both ports held high: grants alternate (all port 0 under fixed priority).
    for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = i % 2;
`endif
      v = '{rst_before: (i == 0), r0: 1'b1, r1: 1'b1, a0: 4'd1, a1: 4'd2,
            exp_v0: (g == 0), exp_v1: (g == 1), exp_data: (g == 1) ? rom[2] : rom[1]};
      vecs.push_back(v);
    end
    v = '{rst_before: 1'b1, r0: 1'b1, r1: 1'b0, a0: 4'd3, a1: 4'd0,
          exp_v0: 1'b1, exp_v1: 1'b0, exp_data: 32'h0000_0003};
    vecs.push_back(v);
    sweep_start = vecs.size();
    for (int i = 0; i < int'(L); i++) begin
      v = '{rst_before: 1'b0, r0: (i % 2 == 0), r1: (i % 2 == 1), a0: 4'(i), a1: 4'(i),
            exp_v0: (i % 2 == 0), exp_v1: (i % 2 == 1), exp_data: rom[i]};
      vecs.push_back(v);
    end

    busy_cnt = 0;
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst_before) do_reset();
      req0 = vecs[k].r0; req1 = vecs[k].r1; addr0 = vecs[k].a0; addr1 = vecs[k].a1;
      tick();
      if (k >= sweep_start) busy_cnt += int'(busy);
      tick();
      if (k >= sweep_start) busy_cnt += int'(busy);
      check("vec_valid0", 32'(valid0), 32'(vecs[k].exp_v0));
      check("vec_valid1", 32'(valid1), 32'(vecs[k].exp_v1));
      check("vec_rdata", rdata, vecs[k].exp_data);
      tick();
      if (k >= sweep_start) busy_cnt += int'(busy);
    end
    check("sweep_busy_2of3", 32'(busy_cnt), 32'(2 * L));
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Address change during READ must not affect the transaction in flight.
    req0 = 1'b1; addr0 = 4'd5;
    tick();
    check("s3_addr_hold_pre", 32'(rom_address), 32'd5);
    addr0 = 4'd9; req0 = 1'b0;
    tick();
    check("s3_rdata", rdata, rom[5]);
    tick();

    // Reset in the middle of READ aborts with no valid pulse.
    req0 = 1'b1; addr0 = 4'd7;
    tick();
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    req1 = 1'b1; addr1 = 4'd15;
    tick();
    req1 = 1'b0;
    tick();
    check("s4_valid1", 32'(valid1), 32'd1);
    check("s4_rdata", rdata, rom[15]);
    tick();

    // Idle period: nothing moves, rdata keeps the last word.
    for (int i = 0; i < 10; i++) tick();
    check("s6_rdata_hold", rdata, rom[15]);
    check("s6_busy", 32'(busy), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      req0  = ($urandom_range(0, 2) == 0);
      req1  = ($urandom_range(0, 2) == 0);
      addr0 = 4'($urandom_range(0, L - 1));
      addr1 = 4'($urandom_range(0, L - 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter W, default 32: ROM word width in bits.
REQ-002 Parameter L, default 16: ROM depth in words; address width is A = $clog2(L).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1 each  read request from requester 0 / requester 1.
REQ-006 addr0 / addr1  input  A each  word address for requester 0 / requester 1.
REQ-007 rom_address  output  A  address to the shared combinational ROM.
REQ-008 rom_oe  output  1  output enable to the ROM.
REQ-009 rom_data  input  W  ROM read data; valid combinationally while rom_oe=1.
REQ-010 rdata  output  W  registered read data, shared by both requesters.
REQ-011 valid0 / valid1  output  1 each  one-cycle pulse: rdata holds the word requested by port 0 / port 1.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, READ and RESP.
REQ-014 IDLE: if any req is high at the rising edge, the FSM SHALL register the winner's address into addr_q and its index into gnt_q, then move to READ; otherwise it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin. When both requests are high, the port not granted last wins. After reset, port 0 has priority.
REQ-016 READ: rom_oe SHALL be 1 and rom_address SHALL equal addr_q.
REQ-017 At the rising edge that ends READ, the block SHALL load rom_data into rdata, assert valid[gnt_q], and move to RESP.
REQ-018 RESP: exactly one valid output SHALL be high for exactly one cycle. At the next rising edge, the FSM SHALL return to IDLE and clear valid.
REQ-019 Latency: a request sampled at rising edge t SHALL produce valid after edge t+1. Throughput is at most one read per 3 cycles.
REQ-020 rom_oe SHALL be 0 in IDLE and RESP. rom_address SHALL always drive addr_q, so it never changes while rom_oe=1.
REQ-021 rdata SHALL hold its last value until the next read completes.
REQ-022 A requester SHALL drop req before the first rising edge in IDLE that follows its valid pulse. A req still high at that edge SHALL be treated as a new request.
REQ-023 Changes on req or addr inputs during READ or RESP SHALL have no effect on the transaction in flight.
REQ-024 valid0 and valid1 SHALL never be high in the same cycle.

Reset
REQ-025 When reset_n=0, the block SHALL immediately and asynchronously force: state=IDLE, addr_q=0, gnt_q=0, last-grant=port 1 (so port 0 wins first), rdata=0, valid0=valid1=0, busy=0, rom_oe=0, rom_address=0.
REQ-026 Reset asserted during READ or RESP SHALL abort the transaction with no valid pulse. After reset_n rises, the first rising edge SHALL behave as IDLE.

Configuration
REQ-027 When macro ROM_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority: port 0 always wins a tie, and the last-grant register is omitted.
REQ-028 When ROM_ARB_FIXED_PRIO_EN is not defined, arbitration SHALL be round-robin as specified in REQ-015.

Verification
REQ-029 Scenario 1: after reset, req0=1, addr0=3, ROM[3]=32'h0000_0003 -> rom_oe=1 with rom_address=3 for one cycle; then valid0=1 with rdata=32'h0000_0003 for one cycle; valid1 stays 0.
REQ-030 Scenario 2: req0 and req1 held high, addr0=1, addr1=2 -> grants alternate 0,1,0,1 with rdata matching ROM[1], ROM[2], ROM[1], ROM[2]. With ROM_ARB_FIXED_PRIO_EN defined, grants are 0,0,0,0.
REQ-031 Scenario 3: single request; addr0 changed from 5 to 9 during READ -> rdata=ROM[5]; rom_address stays 5 while rom_oe=1.
REQ-032 Scenario 4: reset_n pulsed low in the middle of READ -> outputs zero immediately; no valid pulse; the next req1 with addr1=15 returns ROM[15] on valid1.
REQ-033 Scenario 5: sweep addresses 0..L-1 alternately on port 0 and port 1 -> every valid returns the correct word; busy=1 in exactly 2 of every 3 cycles; rom_oe is never 1 outside READ.
REQ-034 Scenario 6: no requests for 10 cycles -> busy=0, rom_oe=0, rdata unchanged.
